// File: rtl/lcd_nibble_xmit.sv
// lcd_nibble_xmit: 4-bit HD44780 bus transmitter, one byte per handshake.
// Optional LCD_LONG_WAIT_EN: long settle after clear/home instructions.
module lcd_nibble_xmit #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int HOLD_CYC      = 2,
  parameter int GAP_CYC       = 50,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nibble,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] sf_d
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HI_SETUP,
    S_HI_PULSE,
    S_HI_HOLD,
    S_GAP,
    S_LO_SETUP,
    S_LO_PULSE,
    S_LO_HOLD,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] L_SETUP =
    CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EHIGH =
    CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD =
    CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_GAP =
    CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] L_WAIT =
    CNT_W'(WAIT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_n;
  logic [7:0]       data_q, data_n;
  logic             nib_q, nib_n;
  logic [CNT_W-1:0] wait_lim;

  logic             e_n;
  logic             lrs_n;
  logic [3:0]       sf_n;
  logic             ready_n;

`ifdef LCD_LONG_WAIT_EN
  localparam logic [CNT_W-1:0] L_LONG =
    CNT_W'(LONG_WAIT_CYC - 1);

  logic long_q, long_n;
  logic is_home;

  // Clear (01) and return-home (02/03) instructions need the long settle.
  assign is_home = (cmd_data[7:2] == 6'd0) &&
                   (cmd_data[1:0] != 2'd0);

  // Long-settle flag captured with the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) long_q <= 1'b0;
    else       long_q <= long_n;
  end

  // Flag is only resampled at accept time.
  always_comb begin
    long_n = long_q;
    if (state_q == S_IDLE && cmd_valid)
      long_n = ~cmd_rs & ~cmd_nibble & is_home;
  end

  assign wait_lim = long_q ? L_LONG : L_WAIT;
`else
  logic unused_long_wait;
  assign unused_long_wait = (LONG_WAIT_CYC == 0);
  assign wait_lim = L_WAIT;
`endif

  // State, phase counter and latched command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      nib_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_n;
      data_q  <= data_n;
      nib_q   <= nib_n;
    end
  end

  // Phase sequencing; every phase ends when the counter hits its limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rs_n    = rs_q;
    data_n  = data_q;
    nib_n   = nib_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d = S_HI_SETUP;
          rs_n    = cmd_rs;
          data_n  = cmd_data;
          nib_n   = cmd_nibble;
        end
      end
      S_HI_SETUP:
        if (cnt_q == L_SETUP) state_d = S_HI_PULSE;
      S_HI_PULSE:
        if (cnt_q == L_EHIGH) state_d = S_HI_HOLD;
      S_HI_HOLD:
        if (cnt_q == L_HOLD)
          state_d = nib_q ? S_WAIT : S_GAP;
      S_GAP:
        if (cnt_q == L_GAP) state_d = S_LO_SETUP;
      S_LO_SETUP:
        if (cnt_q == L_SETUP) state_d = S_LO_PULSE;
      S_LO_PULSE:
        if (cnt_q == L_EHIGH) state_d = S_LO_HOLD;
      S_LO_HOLD:
        if (cnt_q == L_HOLD) state_d = S_WAIT;
      S_WAIT:
        if (cnt_q == wait_lim) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Pin values decoded from the next state so they can be registered.
  always_comb begin
    e_n     = 1'b0;
    lrs_n   = 1'b0;
    sf_n    = 4'h0;
    ready_n = 1'b0;
    unique case (state_d)
      S_IDLE:
        ready_n = 1'b1;
      S_HI_SETUP, S_HI_HOLD: begin
        lrs_n = rs_n;
        sf_n  = data_n[7:4];
      end
      S_HI_PULSE: begin
        e_n   = 1'b1;
        lrs_n = rs_n;
        sf_n  = data_n[7:4];
      end
      S_GAP:
        sf_n = data_n[3:0];
      S_LO_SETUP, S_LO_HOLD: begin
        lrs_n = rs_n;
        sf_n  = data_n[3:0];
      end
      S_LO_PULSE: begin
        e_n   = 1'b1;
        lrs_n = rs_n;
        sf_n  = data_n[3:0];
      end
      default: begin
        e_n   = 1'b0;
        lrs_n = 1'b0;
        sf_n  = 4'h0;
      end
    endcase
  end

  // Registered pins; reset drops lcd_e immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      sf_d      <= 4'h0;
      cmd_ready <= 1'b1;
    end else begin
      lcd_e     <= e_n;
      lcd_rs    <= lrs_n;
      sf_d      <= sf_n;
      cmd_ready <= ready_n;
    end
  end

  assign busy   = ~cmd_ready;
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_xmit.sv
// tb_lcd_nibble_xmit: table-driven scoreboard bench for lcd_nibble_xmit.
// Timeline expectations assume default parameters.
module tb_lcd_nibble_xmit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nibble = 1'b0;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] sf_d;

  lcd_nibble_xmit dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rs     (cmd_rs),
    .cmd_data   (cmd_data),
    .cmd_nibble (cmd_nibble),
    .busy       (busy),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .sf_d       (sf_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       nib;
    int         occ;
  } vec_t;

`ifdef LCD_LONG_WAIT_EN
  localparam int OCC_CLR = 82082;
`else
  localparam int OCC_CLR = 2082;
`endif

  vec_t sb[$];
  vec_t tbl[4];
  vec_t cur;

  int   errors = 0;
  int   checks = 0;
  int   pc = 0;
  int   acc_pc = 0;
  int   done_pc = 0;
  int   rel;
  bit   in_xfer = 1'b0;

  int         npulse, rise1, rise2, len1, len2;
  int         rs_err;
  int         rw_err = 0;
  logic [3:0] nib1, nib2, h_sf, g_sf, w_sf;
  logic       h_rs, g_rs, w_rs;
  bit         e_prev;

  always @(posedge clk) pc <= pc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic start_mon();
    acc_pc = pc;
    npulse = 0;
    rise1  = -1;
    rise2  = -1;
    len1   = 0;
    len2   = 0;
    rs_err = 0;
    nib1   = 'x;
    nib2   = 'x;
    h_sf   = 'x;
    g_sf   = 'x;
    w_sf   = 'x;
    h_rs   = 1'bx;
    g_rs   = 1'bx;
    w_rs   = 1'bx;
    e_prev = 1'b0;
    in_xfer = 1'b1;
  endtask

  // Output monitor: builds the observed timeline, compares on ready.
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_err++;
    if (reset) begin
      if (in_xfer) begin
        void'(sb.pop_front());
        in_xfer = 1'b0;
      end
      e_prev = 1'b0;
    end else if (in_xfer) begin
      rel = pc - acc_pc;
      cur = sb[0];
      if (lcd_e && !e_prev) begin
        npulse++;
        if (npulse == 1) rise1 = rel;
        else             rise2 = rel;
      end
      if (lcd_e) begin
        if (npulse == 1) begin
          len1++;
          nib1 = sf_d;
        end else begin
          len2++;
          nib2 = sf_d;
        end
        if (lcd_rs !== cur.rs) rs_err++;
      end
      if (rel == 14) begin
        h_rs = lcd_rs;
        h_sf = sf_d;
      end
      if (rel == 16) begin
        g_rs = lcd_rs;
        g_sf = sf_d;
      end
      if (rel == (cur.nib ? 16 : 82)) begin
        w_rs = lcd_rs;
        w_sf = sf_d;
      end
      e_prev = lcd_e;
      if (cmd_ready) begin
        done_pc = pc;
        in_xfer = 1'b0;
        void'(sb.pop_front());
        chk("rise1", rise1, 2);
        chk("len1", len1, 12);
        chk("hi_nib", nib1, cur.data[7:4]);
        chk("rs_pulse", rs_err, 0);
        chk("hold_rs", h_rs, cur.rs);
        chk("hold_sf", h_sf, cur.data[7:4]);
        if (cur.nib) begin
          chk("npulse", npulse, 1);
        end else begin
          chk("npulse", npulse, 2);
          chk("gap_rs", g_rs, 0);
          chk("gap_sf", g_sf, cur.data[3:0]);
          chk("rise2", rise2, 68);
          chk("len2", len2, 12);
          chk("lo_nib", nib2, cur.data[3:0]);
        end
        chk("wait_rs", w_rs, 0);
        chk("wait_sf", w_sf, 0);
        chk("occupancy", rel, cur.occ);
      end
    end
  end

  task automatic send(input logic rs,
                      input logic [7:0] d,
                      input logic nib,
                      input int occ,
                      input bit hold,
                      input bit b2b);
    vec_t v;
    int   n;
    cmd_rs     = rs;
    cmd_data   = d;
    cmd_nibble = nib;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      $display("FAIL accept_timeout: got busy expected ready");
      $fatal(1);
    end
    @(posedge clk);
    #1;
    v = '{rs, d, nib, occ};
    sb.push_back(v);
    if (b2b) chk("b2b_accept", pc, done_pc + 1);
    start_mon();
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
    end
    n = 0;
    while (n < 100000) begin
      @(negedge clk);
      n++;
      if (cmd_ready) break;
      if (hold) begin
        cmd_data   = 8'($urandom);
        cmd_rs     = 1'($urandom);
        cmd_nibble = 1'($urandom);
      end
    end
    if (!cmd_ready) begin
      $display("FAIL done_timeout: got busy expected ready");
      $fatal(1);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h28, 1'b0, 2082};
    tbl[1] = '{1'b0, 8'h30, 1'b1, 2016};
    tbl[2] = '{1'b0, 8'h01, 1'b0, OCC_CLR};
    tbl[3] = '{1'b1, 8'h01, 1'b0, 2082};

    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_sf", sf_d, 0);
    #2 reset = 1'b0;
    @(negedge clk);

    // reset in the middle of the low-nibble pulse
    cmd_rs     = 1'b0;
    cmd_data   = 8'h28;
    cmd_nibble = 1'b0;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{1'b0, 8'h28, 1'b0, 2082});
    start_mon();
    cmd_valid = 1'b0;
    repeat (70) @(negedge clk);
    chk("pre_rst_e", lcd_e, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_sf", sf_d, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_rs", lcd_rs, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      send(tbl[i].rs, tbl[i].data, tbl[i].nib,
           tbl[i].occ, 1'b0, 1'b0);

    // valid held with scrambled data, then back-to-back byte
    send(1'b0, 8'hA5, 1'b0, 2082, 1'b1, 1'b0);
    send(1'b1, 8'h41, 1'b0, 2082, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    chk("rw_zero", rw_err, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
